// File: rtl/ab_arith_unit_if.sv
// Operand/result bundle for ab_arith_unit.
//   master: drives in_valid, a, b, ctrl; receives result and flags.
//   slave : receives operands; drives result, carry, overflow, zero,
//           negative, out_valid.
interface ab_arith_unit_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       ctrl;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             out_valid;

    modport master (
        output in_valid, a, b, ctrl,
        input  result, carry, overflow, zero, negative, out_valid
    );

    modport slave (
        input  in_valid, a, b, ctrl,
        output result, carry, overflow, zero, negative, out_valid
    );
endinterface

// File: rtl/ab_arith_unit.sv
// ab_arith_unit: N-bit pass/shift/add/subtract unit with registered result.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - slave side of ab_arith_unit_if (operands in, result/flags out)
// ctrl: 00 pass b, 01 a<<1, 10 a+b, 11 a-b. One-cycle latency, no backpressure.

// 2:1 mux leaf cell.
module mux_2to1 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

// 1-bit full adder leaf cell.
module bitAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ab_arith_unit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic            clk,
    input  logic            reset,
    ab_arith_unit_if.slave  bus
);
    // c[i] is the carry into cell i; c[WIDTH] is the final carry-out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_n;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] pass;
    logic [WIDTH-1:0] op_out;

    // Subtract injects the +1 of two's complement as the chain's carry-in.
    assign c[0] = bus.ctrl[0];
    assign a_sh = {bus.a[WIDTH-2:0], 1'b0};

    // Ripple of per-bit cells.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign b_n[i] = ~bus.b[i];

        mux_2to1 u_bsel (.sel(bus.ctrl[0]), .d0(bus.b[i]), .d1(b_n[i]), .y(b_sel[i]));

        bitAdder u_add (
            .a   (bus.a[i]),
            .b   (b_sel[i]),
            .cin (c[i]),
            .sum (sum[i]),
            .cout(c[i+1])
        );

        mux_2to1 u_pass (.sel(bus.ctrl[0]), .d0(bus.b[i]), .d1(a_sh[i]), .y(pass[i]));
        mux_2to1 u_out  (.sel(bus.ctrl[1]), .d0(pass[i]), .d1(sum[i]), .y(op_out[i]));
    end

    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;
    logic             out_valid_q, out_valid_d;

    // Next-state: load on in_valid, otherwise hold.
    always_comb begin
        result_d    = result_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        negative_d  = negative_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            result_d   = op_out;
            carry_d    = bus.ctrl[1] & c[WIDTH];
            overflow_d = bus.ctrl[1] & (c[WIDTH-1] ^ c[WIDTH]);
            zero_d     = (op_out == '0);
            negative_d = op_out[WIDTH-1];
        end
    end

    // Result and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b1;
            negative_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_ab_arith_unit.sv
// Self-checking bench for ab_arith_unit at WIDTH = 8.
module tb_ab_arith_unit;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] result;
        logic         carry;
        logic         overflow;
        logic         zero;
        logic         negative;
    } exp_t;

    localparam exp_t RST_EXP = {W'(0), 1'b0, 1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t held;
    exp_t obs;
    exp_t e;

    ab_arith_unit_if #(.WIDTH(W)) bus ();

    ab_arith_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.result, bus.carry, bus.overflow, bus.zero, bus.negative};

    // Behavioural reference using ordinary arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] ctrl);
        exp_t       r;
        logic [W:0] s;
        r = '0;
        case (ctrl)
            2'b00: r.result = b;
            2'b01: r.result = {a[W-2:0], 1'b0};
            2'b10: begin
                s          = {1'b0, a} + {1'b0, b};
                r.result   = s[W-1:0];
                r.carry    = s[W];
                r.overflow = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            default: begin
                s          = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                r.result   = s[W-1:0];
                r.carry    = s[W];
                r.overflow = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
            end
        endcase
        r.zero     = (r.result == '0);
        r.negative = r.result[W-1];
        return r;
    endfunction

    // Apply one cycle of stimulus, record expectation, then step past the edge.
    task automatic drive(input logic rst, input logic v, input logic [W-1:0] ai,
                         input logic [W-1:0] bi, input logic [1:0] ci);
        reset        = rst;
        bus.in_valid = v;
        bus.a        = ai;
        bus.b        = bi;
        bus.ctrl     = ci;
        if (rst) begin
            held = RST_EXP;
        end else if (v) begin
            held = model(ai, bi, ci);
            sb.push_back(held);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 8'hFF, 8'h01, 2'b10);
            checks++;
            if (obs !== RST_EXP || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: got %h v=%b want %h v=0", i, obs, bus.out_valid, RST_EXP);
            end
        end
    endtask

    // Directed vectors with hand-written expected values alongside the model.
    task automatic test_directed(input string name, input logic [W-1:0] ai,
                                 input logic [W-1:0] bi, input logic [1:0] ci,
                                 input exp_t want);
        drive(1'b0, 1'b1, ai, bi, ci);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if (obs !== e || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s: got %h v=%b want %h v=1", name, obs, bus.out_valid, e);
            end
        end
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s_const: got %h want %h", name, obs, want);
        end
    endtask

    task automatic test_pass_shift();
        test_directed("pass_b",  8'h12, 8'hA5, 2'b00, {8'hA5, 1'b0, 1'b0, 1'b0, 1'b1});
        test_directed("shift_a", 8'hC3, 8'h00, 2'b01, {8'h86, 1'b0, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic test_add();
        test_directed("add_wrap", 8'hFF, 8'h01, 2'b10, {8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        test_directed("add_ovf",  8'h7F, 8'h01, 2'b10, {8'h80, 1'b0, 1'b1, 1'b0, 1'b1});
    endtask

    task automatic test_sub();
        test_directed("sub_eq",     8'h05, 8'h05, 2'b11, {8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        test_directed("sub_borrow", 8'h00, 8'h01, 2'b11, {8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});
        test_directed("sub_ovf",    8'h80, 8'h01, 2'b11, {8'h7F, 1'b1, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic test_lsb_sweep();
        logic [W-1:0] av, bv;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                av = W'(k & 1);
                bv = W'(k >> 1);
                drive(1'b0, 1'b1, av, bv, 2'(c));
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_sweep: scoreboard empty");
                end else begin
                    e = sb.pop_front();
                    if (obs !== e || bus.out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL lsb_sweep c=%0d a=%h b=%h: got %h v=%b want %h",
                                 c, av, bv, obs, bus.out_valid, e);
                    end
                end
                if (c == 3) begin
                    checks++;
                    if (bus.result[0] !== (av[0] ^ bv[0])) begin
                        errors++;
                        $display("FAIL sub_lsb a=%h b=%h: got %b want %b",
                                 av, bv, bus.result[0], av[0] ^ bv[0]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic [1:0]   tc [3];
        ta[0] = 8'h10; tb[0] = 8'h20; tc[0] = 2'b10;
        ta[1] = 8'h33; tb[1] = 8'h44; tc[1] = 2'b11;
        ta[2] = 8'h81; tb[2] = 8'h5A; tc[2] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, ta[i], tb[i], tc[i]);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL b2b[%0d]: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (obs !== e || bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got %h v=%b want %h v=1", i, obs, bus.out_valid, e);
                end
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, W'($urandom), W'($urandom), 2'($urandom));
            checks++;
            if (obs !== held || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got %h v=%b want %h v=0", i, obs, bus.out_valid, held);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b0, 1'b1, 8'h0F, 8'hF0, 2'b10);
        checks++;
        e = sb.pop_front();
        if (obs !== e || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got %h v=%b want %h v=1", obs, bus.out_valid, e);
        end
        drive(1'b1, 1'b1, 8'hFF, 8'h01, 2'b10);
        checks++;
        if (obs !== RST_EXP || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got %h v=%b want %h v=0", obs, bus.out_valid, RST_EXP);
        end
        drive(1'b0, 1'b1, 8'h03, 8'h01, 2'b11);
        checks++;
        e = sb.pop_front();
        if (obs !== e || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_post: got %h v=%b want %h v=1", obs, bus.out_valid, e);
        end
    endtask

    task automatic test_random();
        logic v;
        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(3, 0) != 0);
            drive(1'b0, v, W'($urandom), W'($urandom), 2'($urandom));
            checks++;
            if (v) begin
                e = sb.pop_front();
                if (obs !== e || bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rand[%0d]: got %h v=%b want %h v=1", i, obs, bus.out_valid, e);
                end
            end else if (obs !== held || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_hold[%0d]: got %h v=%b want %h v=0", i, obs, bus.out_valid, held);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d entries want 0", sb.size());
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 8'hFF;
        bus.b        = 8'h01;
        bus.ctrl     = 2'b10;
        held         = RST_EXP;
        test_reset();
        test_pass_shift();
        test_add();
        test_sub();
        test_lsb_sweep();
        test_back_to_back();
        test_hold();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
